// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with shadowed divisors and phase sync.
// Latency: clk_out/tc/load_err are registered, one clk after the counter state they reflect.
// Backpressure: none; divisor writes are accepted or rejected (load_err) on the strobe cycle.
module clk_div_prog #(
  parameter int CHANNELS    = 3,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                div_load,
  input  logic [3:0]          div_ch,
  input  logic [CNT_W-1:0]    div_val,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tc,
  output logic                load_err
);

  localparam logic [CNT_W-1:0] LP_DEF  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] LP_ZERO = '0;
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_TWO  = CNT_W'(2);

  // Shadow divisor (written by div_load), active divisor (used by the counter)
  logic [CNT_W-1:0]    r_shadow [CHANNELS];
  logic [CNT_W-1:0]    r_div    [CHANNELS];
  logic [CNT_W-1:0]    r_cnt    [CHANNELS];
  logic [CHANNELS-1:0] r_clk_out;
  logic [CHANNELS-1:0] r_tc;
  logic                r_load_err;

  logic [CNT_W-1:0]    w_half   [CHANNELS];
  logic [CNT_W-1:0]    w_last   [CHANNELS];
  logic [CHANNELS-1:0] w_wrap;
  logic                w_load_ok;

  assign clk_out  = r_clk_out;
  assign tc       = r_tc;
  assign load_err = r_load_err;

  // A write needs an existing channel and a divisor of at least 2
  assign w_load_ok = div_load && (int'(div_ch) < CHANNELS) && (div_val >= LP_TWO);

  // Per-channel high-phase length ceil(D/2) and last count D-1, kept at CNT_W bits
  // (D/2 + D[0] avoids the carry that D+1 would produce at D = 2^CNT_W-1)
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_half[c] = (r_div[c] >> 1) + {{(CNT_W-1){1'b0}}, r_div[c][0]};
      w_last[c] = r_div[c] - LP_ONE;
      w_wrap[c] = (r_cnt[c] == w_last[c]);
    end
  end

  // Shadow divisor writes; rejected writes leave every shadow untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= LP_DEF;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_load_ok && (div_ch == 4'(c))) r_shadow[c] <= div_val;
      end
    end
  end

  // Per-channel counter, active divisor and registered outputs; sync beats wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c] <= LP_ZERO;
        r_div[c] <= LP_DEF;
      end
      r_clk_out <= '0;
      r_tc      <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!en[c]) begin
          // Idle: hold at the start of a period and keep tracking the shadow
          r_cnt[c]     <= LP_ZERO;
          r_clk_out[c] <= 1'b0;
          r_tc[c]      <= 1'b0;
          r_div[c]     <= r_shadow[c];
        end else if (sync) begin
          // Output shows cycle 0 of a fresh period; counter already at 1
          r_cnt[c]     <= LP_ONE;
          r_clk_out[c] <= 1'b1;
          r_tc[c]      <= 1'b0;
          r_div[c]     <= r_shadow[c];
        end else begin
          r_clk_out[c] <= (r_cnt[c] < w_half[c]);
          r_tc[c]      <= w_wrap[c];
          if (w_wrap[c]) begin
            // Period boundary: the only point a new divisor is picked up
            r_cnt[c] <= LP_ZERO;
            r_div[c] <= r_shadow[c];
          end else begin
            r_cnt[c] <= r_cnt[c] + LP_ONE;
          end
        end
      end
    end
  end

  // One-cycle flag for a div_load that was refused
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_load_err <= 1'b0;
    else        r_load_err <= div_load && !w_load_ok;
  end

endmodule
